pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage miniRV core (IF/ID/EX/DM/WB).
- Consumes the load-use halt from the hazard/forward detector, the EX-stage redirect, and the DM-stage memory handshake.
- Drives per-stage register write-enables and flushes, the data-memory request, and a post-reset boot hold.
- Arbitrates simultaneous stall, flush and memory-wait events into one consistent set of pipeline controls per cycle.

Parameters:
- BOOT_CYC, 2: cycles held in BOOT after reset release. 0 means RUN at the first clock edge.
- TIMEOUT, 16: maximum consecutive mem_valid cycles without mem_ready before ERR. 0 disables the watchdog.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- lu_halt  in  1  load-use hazard from the detector
- ex_redirect  in  1  EX resolved a taken branch/jump
- dm_mem_op  in  1  DM stage holds a load/store
- mem_ready  in  1  data memory completes the current access
- mem_valid  out  1  data-memory request
- pc_we  out  1  PC write enable
- if_id_we / id_ex_we / ex_dm_we / dm_wb_we  out  1 each  pipeline-register write enables
- if_id_flush / id_ex_flush / dm_wb_flush  out  1 each  load a bubble on the next edge (effective only when the matching we=1)
- mem_err  out  1  sticky memory-timeout error
- state_o  out  2  BOOT=0, RUN=1, WAIT=2, ERR=3
- stall_cnt  out  CNT_W  stall cycles (optional feature)
- flush_cnt  out  CNT_W  accepted redirects (optional feature)

Behaviour:
Structure
- Registered state plus boot counter and wait counter. Outputs are Mealy: combinational from state and current inputs.
- Async reset: state=BOOT, all counters=0.
- Reset mid-operation: immediate return to BOOT. Any in-flight memory access is abandoned: mem_valid=0 at once.

BOOT
- All *_we=1, all flushes=1 (pipe filled with bubbles), pc_we=0, mem_valid=0, mem_err=0.
- Boot counter increments each cycle. Go to RUN when count reaches BOOT_CYC-1.

RUN, priority mem > redirect > load-use:
- dm_mem_op=1 and mem_ready=0:
  - mem_valid=1.
  - pc_we, if_id_we, id_ex_we, ex_dm_we = 0.
  - dm_wb_we=1 with dm_wb_flush=1, so WB never retires twice.
  - Wait counter=1. Next state WAIT, or ERR if TIMEOUT=1.
- Otherwise advance:
  - mem_valid=dm_mem_op; all we=1.
  - ex_redirect=1: if_id_flush=1, id_ex_flush=1; lu_halt ignored.
  - Else lu_halt=1: pc_we=0, if_id_we=0, id_ex_flush=1 (one bubble).
  - Else no flushes.

WAIT
- mem_valid=1.
- mem_ready=0:
  - Same freeze as RUN's first wait cycle; counter increments.
  - When counter+1 reaches TIMEOUT (TIMEOUT≠0), next state ERR.
- mem_ready=1:
  - Identical to the RUN advance case, using the current ex_redirect/lu_halt; these inputs are stable because EX and ID were frozen.
  - Counter cleared; next state RUN.

ERR
- All we=0, flushes=0, mem_valid=0, mem_err=1.
- Held until reset.

Rules
- Counter width is $clog2(TIMEOUT+1), minimum 1.
- mem_ready while mem_valid=0 is ignored.

Optional Feature:
PIPE_PERF_EN
- Defined:
  - stall_cnt increments on each RUN/WAIT cycle with pc_we=0.
  - flush_cnt increments on each cycle where a redirect is applied (if_id_flush=1 outside BOOT).
  - Both counters wrap at 2^CNT_W and reset to 0.
- Undefined: both ports tied to 0 and no counter flops.

Test Plan:
1. Reset, BOOT_CYC=2 -> state_o 0,0 then 1; pc_we=0 and flushes=1 for exactly 2 cycles.
2. RUN, lu_halt=1 for 1 cycle -> pc_we=0, if_id_we=0, id_ex_flush=1 that cycle; the next cycle has all we=1 and no flush.
3. RUN, ex_redirect=1 and lu_halt=1 together -> if_id_flush=id_ex_flush=1, pc_we=1; with PIPE_PERF_EN, flush_cnt 0->1 and stall_cnt unchanged.
4. dm_mem_op=1 with mem_ready after 3 cycles:
   - mem_valid=1 for 4 cycles; pc_we=0 for 3 cycles; dm_wb_flush=1 for 3 cycles.
   - state 1->2->2->2->1.
   - With ex_redirect held, the flush is applied only on the ready cycle.
5. TIMEOUT=4, mem_ready never asserted -> ERR after 4 mem_valid cycles; mem_err=1 and all we=0 thereafter. Assert rst_n=0 mid-ERR -> BOOT and mem_err=0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the miniRV pipeline and pipe_ctrl.
// The master side is the datapath; the slave side is the controller.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             lu_halt;
  logic             ex_redirect;
  logic             dm_mem_op;
  logic             mem_ready;
  logic             mem_valid;
  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_dm_we;
  logic             dm_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             dm_wb_flush;
  logic             mem_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output lu_halt,
    output ex_redirect,
    output dm_mem_op,
    output mem_ready,
    input  mem_valid,
    input  pc_we,
    input  if_id_we,
    input  id_ex_we,
    input  ex_dm_we,
    input  dm_wb_we,
    input  if_id_flush,
    input  id_ex_flush,
    input  dm_wb_flush,
    input  mem_err,
    input  state_o,
    input  stall_cnt,
    input  flush_cnt
  );

  modport slave (
    input  lu_halt,
    input  ex_redirect,
    input  dm_mem_op,
    input  mem_ready,
    output mem_valid,
    output pc_we,
    output if_id_we,
    output id_ex_we,
    output ex_dm_we,
    output dm_wb_we,
    output if_id_flush,
    output id_ex_flush,
    output dm_wb_flush,
    output mem_err,
    output state_o,
    output stall_cnt,
    output flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// miniRV 5-stage sequencing controller: boot hold, stalls, flushes, mem wait.
// Define PIPE_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl #(
  parameter int BOOT_CYC = 2,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BOOT_LAST =
    BW'((BOOT_CYC > 1) ? BOOT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WW-1:0]   wait_nxt;
  logic            pend;
  logic            hold;
  logic            to_hit;

  logic mem_valid;
  logic pc_we;
  logic if_id_we;
  logic id_ex_we;
  logic ex_dm_we;
  logic dm_wb_we;
  logic if_id_flush;
  logic id_ex_flush;
  logic dm_wb_flush;
  logic mem_err;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wait_nxt    = '0;
    pend        = 1'b0;
    hold        = 1'b0;
    to_hit      = 1'b0;
    mem_valid   = 1'b0;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_dm_we    = 1'b0;
    dm_wb_we    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    dm_wb_flush = 1'b0;
    mem_err     = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_dm_we    = 1'b1;
        dm_wb_we    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        dm_wb_flush = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = S_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      S_RUN, S_WAIT: begin
        // WAIT keeps the request alive even if DM's op bit glitches
        pend = bus.dm_mem_op | (state_q == S_WAIT);
        hold = pend & ~bus.mem_ready;
        if (state_q == S_WAIT) begin
          wait_nxt = wait_cnt_q + 1'b1;
        end else begin
          wait_nxt = WW'(1);
        end
        to_hit = (TIMEOUT != 0) && (32'(wait_nxt) == TIMEOUT);

        if (hold) begin
          // DM->WB takes a bubble so the stalled op retires once
          mem_valid   = 1'b1;
          dm_wb_we    = 1'b1;
          dm_wb_flush = 1'b1;
          wait_cnt_d  = wait_nxt;
          state_d     = to_hit ? S_ERR : S_WAIT;
        end else begin
          mem_valid  = pend;
          pc_we      = 1'b1;
          if_id_we   = 1'b1;
          id_ex_we   = 1'b1;
          ex_dm_we   = 1'b1;
          dm_wb_we   = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_RUN;
          unique case (1'b1)
            bus.ex_redirect: begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end
            bus.lu_halt & ~bus.ex_redirect: begin
              pc_we       = 1'b0;
              if_id_we    = 1'b0;
              id_ex_flush = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_ERR: begin
        mem_err = 1'b1;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.mem_valid   = mem_valid;
  assign bus.pc_we       = pc_we;
  assign bus.if_id_we    = if_id_we;
  assign bus.id_ex_we    = id_ex_we;
  assign bus.ex_dm_we    = ex_dm_we;
  assign bus.dm_wb_we    = dm_wb_we;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.dm_wb_flush = dm_wb_flush;
  assign bus.mem_err     = mem_err;
  assign bus.state_o     = state_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             run_like;

  assign run_like = (state_q == S_RUN) | (state_q == S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (run_like & ~pc_we) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (if_id_flush & (state_q != S_BOOT)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
